// File: rtl/fp32_pkg.sv
// Shared field positions, constants and FSM state encoding for the
// binary32 add/subtract sequencer.
package fp32_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MANT_MSB = 22;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam int          EXP_MAX = 255;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    DONE
  } state_e;

endpackage

// File: rtl/fp32_unpack.sv
// Splits a binary32 word into sign, exponent and hidden-bit mantissa and
// classifies it. Exponent-zero inputs (zero and subnormal) flush to zero.
module fp32_unpack
  import fp32_pkg::*;
(
  input  logic [31:0]                word_i,
  output logic                       sign_o,
  output logic [EXP_MSB-EXP_LSB:0]   exp_o,
  output logic [MANT_MSB+1:0]        mant_o,
  output logic                       is_zero_o,
  output logic                       is_inf_o,
  output logic                       is_nan_o
);

  logic expAllOnes;
  logic fracNonZero;

  assign sign_o      = word_i[SIGN_BIT];
  assign exp_o       = word_i[EXP_MSB:EXP_LSB];
  assign expAllOnes  = (exp_o == '1);
  assign fracNonZero = |word_i[MANT_MSB:0];

  assign is_zero_o = (exp_o == '0);
  assign is_inf_o  = expAllOnes && !fracNonZero;
  assign is_nan_o  = expAllOnes && fracNonZero;
  assign mant_o    = is_zero_o ? '0 : {1'b1, word_i[MANT_MSB:0]};

endmodule

// File: rtl/fp32_add_sequencer.sv
// Multi-cycle binary32 adder/subtractor: serial one-bit-per-cycle alignment
// and normalization around a single mantissa add, with valid/ready on both sides.
module fp32_add_sequencer
  import fp32_pkg::*;
#(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        In_Valid,
  output logic        In_Ready,
  input  logic [31:0] In_A,
  input  logic [31:0] In_B,
  output logic        Out_Valid,
  input  logic        Out_Ready,
  output logic [31:0] Out_Result,
  output logic        Busy
);

  state_e            state_q, state_d;
  logic              sign_q, sign_d;
  logic              sub_q, sub_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [EXP_W-1:0]  cnt_q, cnt_d;
  logic [MANT_W-1:0] mantL_q, mantL_d;
  logic [MANT_W-1:0] mantS_q, mantS_d;
  logic [MANT_W:0]   sum_q, sum_d;
  logic [31:0]       result_q, result_d;

  logic              aSign, bSign, aZero, bZero, aInf, bInf, aNan, bNan;
  logic [EXP_W-1:0]  aExp, bExp;
  logic [MANT_W-1:0] aMant, bMant;

  fp32_unpack uUnpackA (
    .word_i    (In_A),
    .sign_o    (aSign),
    .exp_o     (aExp),
    .mant_o    (aMant),
    .is_zero_o (aZero),
    .is_inf_o  (aInf),
    .is_nan_o  (aNan)
  );

  fp32_unpack uUnpackB (
    .word_i    (In_B),
    .sign_o    (bSign),
    .exp_o     (bExp),
    .mant_o    (bMant),
    .is_zero_o (bZero),
    .is_inf_o  (bInf),
    .is_nan_o  (bNan)
  );

  logic              aGe, lSign, sSign, sZero, special, farApart;
  logic [EXP_W-1:0]  lExp, sExp, diff;
  logic [MANT_W-1:0] lMant, sMant;
  logic [31:0]       specialRes;
  logic [MANT_W:0]   addRes;

  // Order by magnitude so the subtraction below can never go negative.
  always_comb begin
    aGe      = {aExp, aMant} >= {bExp, bMant};
    lSign    = aGe ? aSign : bSign;
    sSign    = aGe ? bSign : aSign;
    lExp     = aGe ? aExp  : bExp;
    sExp     = aGe ? bExp  : aExp;
    lMant    = aGe ? aMant : bMant;
    sMant    = aGe ? bMant : aMant;
    sZero    = aGe ? bZero : aZero;
    diff     = lExp - sExp;
    farApart = diff > EXP_W'(MANT_W);
    special  = aNan | bNan | aInf | bInf;
    if (aNan || bNan || (aInf && bInf && (aSign != bSign))) begin
      specialRes = QNAN;
    end else if (aInf) begin
      specialRes = {aSign, POS_INF[30:0]};
    end else begin
      specialRes = {bSign, POS_INF[30:0]};
    end
  end

  assign addRes = sub_q ? ({1'b0, mantL_q} - {1'b0, mantS_q})
                        : ({1'b0, mantL_q} + {1'b0, mantS_q});

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    sub_d     = sub_q;
    exp_d     = exp_q;
    cnt_d     = cnt_q;
    mantL_d   = mantL_q;
    mantS_d   = mantS_q;
    sum_d     = sum_q;
    result_d  = result_q;
    In_Ready  = 1'b0;
    Out_Valid = 1'b0;
    case (state_q)
      IDLE: begin
        In_Ready = 1'b1;
        if (In_Valid) begin
          sign_d  = lSign;
          sub_d   = lSign ^ sSign;
          exp_d   = lExp;
          cnt_d   = diff;
          mantL_d = lMant;
          mantS_d = (sZero || farApart) ? '0 : sMant;
          if (special) begin
            result_d = specialRes;
            state_d  = DONE;
          end else if (diff == '0 || farApart) begin
            state_d = ADD;
          end else begin
            state_d = ALIGN;
          end
        end
      end
      ALIGN: begin
        mantS_d = mantS_q >> 1;
        cnt_d   = cnt_q - EXP_W'(1);
        if (cnt_q == EXP_W'(1)) begin
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d = addRes;
        if (addRes == '0) begin
          result_d = '0;
          state_d  = DONE;
        end else begin
          state_d = NORM;
        end
      end
      // One normalization step per cycle; overflow and underflow end early.
      NORM: begin
        if (sum_q[MANT_W]) begin
          sum_d = sum_q >> 1;
          exp_d = exp_q + EXP_W'(1);
          if (exp_q == EXP_W'(EXP_MAX - 1)) begin
            result_d = {sign_q, POS_INF[30:0]};
            state_d  = DONE;
          end
        end else if (sum_q[MANT_W-1]) begin
          result_d = {sign_q, exp_q, sum_q[MANT_W-2:0]};
          state_d  = DONE;
        end else begin
          sum_d = sum_q << 1;
          exp_d = exp_q - EXP_W'(1);
          if (exp_q == EXP_W'(1)) begin
            result_d = {sign_q, 31'b0};
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        Out_Valid = 1'b1;
        if (Out_Ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      sub_q    <= 1'b0;
      exp_q    <= '0;
      cnt_q    <= '0;
      mantL_q  <= '0;
      mantS_q  <= '0;
      sum_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      sub_q    <= sub_d;
      exp_q    <= exp_d;
      cnt_q    <= cnt_d;
      mantL_q  <= mantL_d;
      mantS_q  <= mantS_d;
      sum_q    <= sum_d;
      result_q <= result_d;
    end
  end

  assign Out_Result = result_q;
  assign Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fp32_add_sequencer.sv
// Bench for fp32_add_sequencer: directed cases with known answers, then
// random operand pairs against a truncating binary32 reference model.
module tb_fp32_add_sequencer;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        In_Valid = 1'b0;
  logic        In_Ready;
  logic [31:0] In_A = '0;
  logic [31:0] In_B = '0;
  logic        Out_Valid;
  logic        Out_Ready = 1'b0;
  logic [31:0] Out_Result;
  logic        Busy;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  fp32_add_sequencer #(.MANT_W(24), .EXP_W(8)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .In_Valid   (In_Valid),
    .In_Ready   (In_Ready),
    .In_A       (In_A),
    .In_B       (In_B),
    .Out_Valid  (Out_Valid),
    .Out_Ready  (Out_Ready),
    .Out_Result (Out_Result),
    .Busy       (Busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
    end
  endtask

  // Reference: IEEE fields, truncating alignment, 1-bit-per-cycle normalization.
  function automatic void refAdd(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output int lat);
    int   ea, eb, ma, mb, eL, eS, mL, mS, diff, shifts, sum, e, cyc;
    logic sL, sS, nanA, nanB, infA, infB, aBig, done;
    ea   = int'(a[30:23]);
    eb   = int'(b[30:23]);
    nanA = (ea == 255) && (a[22:0] != 23'd0);
    nanB = (eb == 255) && (b[22:0] != 23'd0);
    infA = (ea == 255) && (a[22:0] == 23'd0);
    infB = (eb == 255) && (b[22:0] == 23'd0);
    res  = '0;
    lat  = 1;
    if (nanA || nanB || (infA && infB && (a[31] != b[31]))) begin
      res = 32'h7FC0_0000;
      return;
    end
    if (infA) begin res = a; return; end
    if (infB) begin res = b; return; end
    ma   = (ea == 0) ? 0 : int'({1'b1, a[22:0]});
    mb   = (eb == 0) ? 0 : int'({1'b1, b[22:0]});
    aBig = (ea > eb) || ((ea == eb) && (ma >= mb));
    eL = aBig ? ea : eb;   eS = aBig ? eb : ea;
    mL = aBig ? ma : mb;   mS = aBig ? mb : ma;
    sL = aBig ? a[31] : b[31];
    sS = aBig ? b[31] : a[31];
    diff = eL - eS;
    if (diff > 24) begin
      mS = 0;
      shifts = 0;
    end else begin
      mS = mS >> diff;
      shifts = diff;
    end
    sum = (sL == sS) ? (mL + mS) : (mL - mS);
    if (sum == 0) begin
      lat = 2;
      return;
    end
    e = eL;
    cyc = 0;
    done = 1'b0;
    while (!done) begin
      cyc++;
      if (sum >= (1 << 24)) begin
        sum = sum >> 1;
        e++;
        if (e == 255) begin res = {sL, 8'hFF, 23'd0}; done = 1'b1; end
      end else if (sum >= (1 << 23)) begin
        res = {sL, 8'(e), 23'(sum)};
        done = 1'b1;
      end else begin
        sum = sum << 1;
        e--;
        if (e == 0) begin res = {sL, 31'd0}; done = 1'b1; end
      end
    end
    lat = 2 + shifts + cyc;
  endfunction

  // One full transaction: accept, measure latency, stall, then handshake out.
  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input int stall, input logic [31:0] expRes,
                               output logic [31:0] gotRes, output int latency);
    int guard;
    @(negedge Clk);
    In_A = a;
    In_B = b;
    In_Valid = 1'b1;
    guard = 0;
    while (In_Ready !== 1'b1 && guard < 50) begin
      @(negedge Clk);
      guard++;
    end
    checkOutput({tag, "_ready"}, {31'b0, In_Ready}, 32'd1);
    @(posedge Clk);
    #1;
    In_Valid = 1'b0;
    In_A = $urandom;
    In_B = $urandom;
    checkOutput({tag, "_busy"}, {30'b0, In_Ready, Busy}, 32'd1);
    latency = 1;
    while (Out_Valid !== 1'b1 && latency < 300) begin
      @(posedge Clk);
      #1;
      latency++;
    end
    checkOutput({tag, "_valid"}, {31'b0, Out_Valid}, 32'd1);
    gotRes = Out_Result;
    for (int i = 0; i < stall; i++) begin
      @(posedge Clk);
      #1;
      checkOutput({tag, "_hold_res"}, Out_Result, expRes);
      checkOutput({tag, "_hold_flags"}, {30'b0, Out_Valid, In_Ready}, 32'd2);
    end
    Out_Ready = 1'b1;
    @(posedge Clk);
    #1;
    Out_Ready = 1'b0;
    checkOutput({tag, "_idle"}, {29'b0, Out_Valid, In_Ready, Busy}, 32'b010);
  endtask

  task automatic runCase(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int stall, input logic [31:0] expRes, input int expLat);
    logic [31:0] gotRes;
    int          gotLat;
    applyStimulus(tag, a, b, stall, expRes, gotRes, gotLat);
    checkOutput({tag, "_res"}, gotRes, expRes);
    if (expLat > 0) begin
      checkOutput({tag, "_lat"}, 32'(gotLat), 32'(expLat));
    end
  endtask

  initial begin
    logic [31:0] ra, rb, expR;
    int          expL, mode, expA, expB, stall;
    logic        sawValid;

    #2 Reset_n = 1'b0;
    #1;
    checkOutput("reset_flags", {29'b0, Out_Valid, In_Ready, Busy}, 32'b010);
    checkOutput("reset_result", Out_Result, 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;

    runCase("one_plus_one", 32'h3F80_0000, 32'h3F80_0000, 0, 32'h4000_0000, 4);
    runCase("three_minus_one", 32'h4040_0000, 32'hBF80_0000, 1, 32'h4000_0000, 4);
    runCase("exact_cancel", 32'h3FC0_0000, 32'hBFC0_0000, 0, 32'h0000_0000, 2);
    runCase("far_apart", 32'h3F80_0000, 32'h3080_0000, 2, 32'h3F80_0000, 3);
    runCase("overflow", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 0, 32'h7F80_0000, 0);
    runCase("inf_minus_inf", 32'h7F80_0000, 32'hFF80_0000, 0, 32'h7FC0_0000, 1);
    runCase("deep_cancel", 32'h3F80_0001, 32'hBF80_0000, 0, 32'h3400_0000, 26);

    // Abort an operation in the middle of alignment (diff = 23).
    @(negedge Clk);
    In_A = 32'h4B00_0000;
    In_B = 32'h3F80_0000;
    In_Valid = 1'b1;
    @(posedge Clk);
    #1;
    In_Valid = 1'b0;
    repeat (5) @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    checkOutput("abort_flags", {29'b0, Out_Valid, In_Ready, Busy}, 32'b010);
    checkOutput("abort_result", Out_Result, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    sawValid = 1'b0;
    repeat (40) begin
      @(posedge Clk);
      #1;
      if (Out_Valid === 1'b1) sawValid = 1'b1;
    end
    checkOutput("abort_no_output", {31'b0, sawValid}, 32'd0);
    runCase("stall_after_abort", 32'h3F80_0000, 32'h3F80_0000, 5, 32'h4000_0000, 4);

    for (int t = 0; t < 40; t++) begin
      mode = int'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case (mode)
        1: begin
          expA = int'($urandom_range(30, 220));
          expB = expA + int'($urandom_range(0, 60)) - 30;
          ra[30:23] = expA[7:0];
          rb[30:23] = expB[7:0];
        end
        2: begin
          rb = {~ra[31], ra[30:0]};
          rb[3:0] = 4'($urandom);
        end
        3: begin
          ra[30:23] = 8'hFF;
          if ($urandom_range(0, 1) == 1) rb[30:23] = 8'hFF;
          if ($urandom_range(0, 1) == 1) ra[22:0] = 23'd0;
        end
        default: ;
      endcase
      refAdd(ra, rb, expR, expL);
      stall = int'($urandom_range(0, 2));
      runCase($sformatf("rand%0d", t), ra, rb, stall, expR, expL);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
